// File: rtl/fnd_sched_pkg.sv
// Shared types and helpers for the FND display scheduler.
// Holds the mode enum, the blank selector code and the round-robin picker.
package fnd_sched_pkg;

   typedef enum logic [1:0] {
      StManual,
      StRotate,
      StHold
   } state_e;

   localparam logic [1:0] SelBlank = 2'd3;
   localparam int unsigned NumRegs = 3;

   // First set bit of pending, scanning upward from rr_last+1 and wrapping mod 3.
   function automatic logic [2:0] rr_pick(input logic [2:0] pending, input logic [1:0] rr_last);
      logic [2:0] grant;
      logic [1:0] idx;
      grant = 3'b000;
      idx   = rr_last;
      for (int k = 0; k < NumRegs; k++) begin
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         if ((grant == 3'b000) && pending[idx]) begin
            grant[idx] = 1'b1;
         end
      end
      return grant;
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
      logic [1:0] idx;
      case (oh)
         3'b001:  idx = 2'd0;
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = SelBlank;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every TickDiv clock cycles.
// Never re-aligned, so consumers see intervals of (N-1, N] tick periods.
module fnd_tick_gen #(
   parameter int unsigned TickDiv = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CntW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TickDiv - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CntLast);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fnd_disp_scheduler.sv
// Chooses which slave register the FND shows: manual switch select, timed rotation,
// or a hold window after an I2C write, with round-robin service of queued writes.
module fnd_disp_scheduler
   import fnd_sched_pkg::*;
#(
   parameter int unsigned TickDiv     = 100000,
   parameter int unsigned RotateTicks = 1000,
   parameter int unsigned HoldTicks   = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] sw,
   input  logic       auto_en,
   input  logic [2:0] wr_strb,
   input  logic [7:0] slv_reg0,
   input  logic [7:0] slv_reg1,
   input  logic [7:0] slv_reg2,
   output logic [7:0] fnd_reg,
   output logic [1:0] fnd_sel,
   output logic       hold_active
);

   localparam int unsigned RotW  = $clog2(RotateTicks + 1);
   localparam int unsigned HoldW = $clog2(HoldTicks + 1);

   logic tick;

   fnd_tick_gen #(
      .TickDiv(TickDiv)
   ) u_tick_gen (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   state_e            state_q, state_d;
   logic [2:0]        pending_q, pending_d;
   logic [1:0]        rr_last_q, rr_last_d;
   logic [1:0]        rot_idx_q, rot_idx_d;
   logic [RotW-1:0]   rot_cnt_q, rot_cnt_d;
   logic [1:0]        hold_idx_q, hold_idx_d;
   logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
   logic [1:0]        fnd_sel_q, fnd_sel_d;
   logic [7:0]        fnd_reg_q, fnd_reg_d;
   logic              hold_active_q, hold_active_d;

   logic [2:0] held_oh, grant, absorb;
   logic [1:0] grant_idx, man_sel;
   logic       in_hold, restart, hold_expire, grant_en, rot_wrap;

   assign in_hold  = (state_q == StHold);
   assign held_oh  = 3'b001 << hold_idx_q;
   // A rewrite of the shown register restarts the window and wins over a same-cycle expiry.
   assign restart  = in_hold && |(wr_strb & held_oh);
   assign hold_expire = in_hold && tick && !restart && (hold_cnt_q == HoldW'(HoldTicks - 1));
   assign grant_en = (pending_q != 3'b000) && (!in_hold || hold_expire);
   assign grant    = grant_en ? rr_pick(pending_q, rr_last_q) : 3'b000;
   assign grant_idx = onehot_idx(grant);
   assign absorb   = (in_hold ? held_oh : 3'b000) | grant;
   assign rot_wrap = tick && (rot_cnt_q == RotW'(RotateTicks - 1));

   always_comb begin
      case (sw)
         3'b001:  man_sel = 2'd0;
         3'b010:  man_sel = 2'd1;
         3'b100:  man_sel = 2'd2;
         default: man_sel = SelBlank;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pending_d  = (pending_q & ~grant) | (wr_strb & ~absorb);
      rr_last_d  = rr_last_q;
      rot_idx_d  = rot_idx_q;
      rot_cnt_d  = rot_cnt_q;
      hold_idx_d = hold_idx_q;
      hold_cnt_d = hold_cnt_q;

      if (grant_en) begin
         state_d    = StHold;
         rr_last_d  = grant_idx;
         hold_idx_d = grant_idx;
         hold_cnt_d = '0;
      end else begin
         case (state_q)
            StManual: begin
               if (auto_en) state_d = StRotate;
            end
            StRotate: begin
               if (!auto_en) begin
                  state_d = StManual;
               end else if (rot_wrap) begin
                  rot_cnt_d = '0;
                  rot_idx_d = (rot_idx_q == 2'd2) ? 2'd0 : rot_idx_q + 2'd1;
               end else if (tick) begin
                  rot_cnt_d = rot_cnt_q + 1'b1;
               end
            end
            StHold: begin
               if (restart) begin
                  hold_cnt_d = '0;
               end else if (hold_expire) begin
                  state_d = auto_en ? StRotate : StManual;
               end else if (tick) begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            default: state_d = StManual;
         endcase
      end

      // Every entry into rotation starts a fresh dwell; the index itself is kept.
      if (state_d != StRotate) rot_cnt_d = '0;
   end

   // Outputs are registered from the next state so a decision shows one cycle later.
   always_comb begin
      case (state_d)
         StHold:   fnd_sel_d = hold_idx_d;
         StRotate: fnd_sel_d = rot_idx_d;
         default:  fnd_sel_d = man_sel;
      endcase

      case (fnd_sel_d)
         2'd0:    fnd_reg_d = slv_reg0;
         2'd1:    fnd_reg_d = slv_reg1;
         2'd2:    fnd_reg_d = slv_reg2;
         default: fnd_reg_d = 8'h00;
      endcase

      hold_active_d = (state_d == StHold);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StManual;
         pending_q     <= 3'b000;
         rr_last_q     <= 2'd2;
         rot_idx_q     <= 2'd0;
         rot_cnt_q     <= '0;
         hold_idx_q    <= 2'd0;
         hold_cnt_q    <= '0;
         fnd_sel_q     <= SelBlank;
         fnd_reg_q     <= 8'h00;
         hold_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         rr_last_q     <= rr_last_d;
         rot_idx_q     <= rot_idx_d;
         rot_cnt_q     <= rot_cnt_d;
         hold_idx_q    <= hold_idx_d;
         hold_cnt_q    <= hold_cnt_d;
         fnd_sel_q     <= fnd_sel_d;
         fnd_reg_q     <= fnd_reg_d;
         hold_active_q <= hold_active_d;
      end
   end

   assign fnd_sel     = fnd_sel_q;
   assign fnd_reg     = fnd_reg_q;
   assign hold_active = hold_active_q;

endmodule

// File: tb/tb_fnd_disp_scheduler.sv
// Directed bench for fnd_disp_scheduler with a 4-cycle tick, 3-tick rotation and 5-tick hold.
module tb_fnd_disp_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] sw;
   logic       auto_en;
   logic [2:0] wr_strb;
   logic [7:0] slv_reg0, slv_reg1, slv_reg2;
   logic [7:0] fnd_reg;
   logic [1:0] fnd_sel;
   logic       hold_active;

   int passes = 0;
   int total  = 0;

   fnd_disp_scheduler #(
      .TickDiv    (4),
      .RotateTicks(3),
      .HoldTicks  (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw         (sw),
      .auto_en    (auto_en),
      .wr_strb    (wr_strb),
      .slv_reg0   (slv_reg0),
      .slv_reg1   (slv_reg1),
      .slv_reg2   (slv_reg2),
      .fnd_reg    (fnd_reg),
      .fnd_sel    (fnd_sel),
      .hold_active(hold_active)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1; sw = 3'b000; auto_en = 1'b0; wr_strb = 3'b000;
      slv_reg0 = 8'h00; slv_reg1 = 8'h77; slv_reg2 = 8'h00;
      cycles(3);
      total++; if (fnd_sel !== 2'd3) $display("FAIL reset_sel got %0d want 3", fnd_sel); else passes++;
      total++; if (fnd_reg !== 8'h00) $display("FAIL reset_reg got %h want 00", fnd_reg); else passes++;
      total++; if (hold_active !== 1'b0) $display("FAIL reset_hold got %b want 0", hold_active); else passes++;
      reset = 1'b0;
      sw = 3'b001;
      cyc();
      wr_strb = 3'b010; cyc(); wr_strb = 3'b000;
      cyc();
      total++; if (fnd_sel !== 2'd1) $display("FAIL prehold_sel got %0d want 1", fnd_sel); else passes++;
      total++; if (hold_active !== 1'b1) $display("FAIL prehold_act got %b want 1", hold_active); else passes++;
      wr_strb = 3'b001; cyc(); wr_strb = 3'b000;
      total++; if (dut.pending_q !== 3'b001) $display("FAIL prehold_pend got %b want 001", dut.pending_q); else passes++;
      reset = 1'b1; cyc();
      total++; if (fnd_sel !== 2'd3) $display("FAIL midhold_rst_sel got %0d want 3", fnd_sel); else passes++;
      total++; if (fnd_reg !== 8'h00) $display("FAIL midhold_rst_reg got %h want 00", fnd_reg); else passes++;
      total++; if (hold_active !== 1'b0) $display("FAIL midhold_rst_act got %b want 0", hold_active); else passes++;
      total++; if (dut.pending_q !== 3'b000) $display("FAIL midhold_rst_pend got %b want 000", dut.pending_q); else passes++;
      reset = 1'b0;
   endtask

   task automatic test_manual();
      sw = 3'b010; slv_reg1 = 8'h5A; cyc();
      total++; if (fnd_sel !== 2'd1) $display("FAIL man010_sel got %0d want 1", fnd_sel); else passes++;
      total++; if (fnd_reg !== 8'h5A) $display("FAIL man010_reg got %h want 5a", fnd_reg); else passes++;
      sw = 3'b011; cyc();
      total++; if (fnd_sel !== 2'd3) $display("FAIL man011_sel got %0d want 3", fnd_sel); else passes++;
      total++; if (fnd_reg !== 8'h00) $display("FAIL man011_reg got %h want 00", fnd_reg); else passes++;
      sw = 3'b100; slv_reg2 = 8'h3C; cyc();
      total++; if (fnd_sel !== 2'd2) $display("FAIL man100_sel got %0d want 2", fnd_sel); else passes++;
      total++; if (fnd_reg !== 8'h3C) $display("FAIL man100_reg got %h want 3c", fnd_reg); else passes++;
   endtask

   task automatic test_rotate();
      logic [7:0] exp_seq [3];
      logic [7:0] prev;
      int n;
      exp_seq[0] = 8'hB2; exp_seq[1] = 8'hC3; exp_seq[2] = 8'hA1;
      slv_reg0 = 8'hA1; slv_reg1 = 8'hB2; slv_reg2 = 8'hC3;
      sw = 3'b000; auto_en = 1'b1; cyc();
      total++; if (fnd_reg !== 8'hA1) $display("FAIL rot_start got %h want a1", fnd_reg); else passes++;
      for (int i = 0; i < 3; i++) begin
         prev = fnd_reg; n = 0;
         do begin cyc(); n++; end while (fnd_reg === prev && n < 20);
         total++; if (n < 9 || n > 12) $display("FAIL rot_dwell%0d got %0d cycles want 9..12", i, n); else passes++;
         total++; if (fnd_reg !== exp_seq[i]) $display("FAIL rot_val%0d got %h want %h", i, fnd_reg, exp_seq[i]); else passes++;
      end
      n = 0;
      do begin cyc(); n++; end while (fnd_reg !== 8'hB2 && n < 20);
      sw = 3'b100; auto_en = 1'b0; cyc();
      total++; if (fnd_sel !== 2'd2) $display("FAIL rot_off_sel got %0d want 2", fnd_sel); else passes++;
      total++; if (fnd_reg !== 8'hC3) $display("FAIL rot_off_reg got %h want c3", fnd_reg); else passes++;
      auto_en = 1'b1; cyc();
      total++; if (fnd_sel !== 2'd1) $display("FAIL rot_keep_idx got %0d want 1", fnd_sel); else passes++;
      auto_en = 1'b0; sw = 3'b001; cyc();
   endtask

   task automatic test_write_hold();
      int n;
      wr_strb = 3'b100; cyc(); wr_strb = 3'b000;
      total++; if (fnd_sel !== 2'd0) $display("FAIL wr_lat1_sel got %0d want 0", fnd_sel); else passes++;
      cyc();
      total++; if (fnd_sel !== 2'd2) $display("FAIL wr_lat2_sel got %0d want 2", fnd_sel); else passes++;
      total++; if (hold_active !== 1'b1) $display("FAIL wr_lat2_act got %b want 1", hold_active); else passes++;
      total++; if (fnd_reg !== 8'hC3) $display("FAIL wr_lat2_reg got %h want c3", fnd_reg); else passes++;
      n = 0;
      do begin cyc(); n++; end while (fnd_sel === 2'd2 && n < 30);
      total++; if (n < 17 || n > 20) $display("FAIL wr_hold_len got %0d cycles want 17..20", n); else passes++;
      total++; if (fnd_sel !== 2'd0) $display("FAIL wr_back_sel got %0d want 0", fnd_sel); else passes++;
      total++; if (hold_active !== 1'b0) $display("FAIL wr_back_act got %b want 0", hold_active); else passes++;
      total++; if (fnd_reg !== 8'hA1) $display("FAIL wr_back_reg got %h want a1", fnd_reg); else passes++;
   endtask

   task automatic test_hold_restart();
      int n;
      wr_strb = 3'b100; cyc(); wr_strb = 3'b000;
      cyc();
      cycles(10);
      wr_strb = 3'b100; cyc(); wr_strb = 3'b000;
      total++; if (dut.pending_q !== 3'b000) $display("FAIL rst_pend got %b want 000", dut.pending_q); else passes++;
      total++; if (hold_active !== 1'b1 || fnd_sel !== 2'd2)
         $display("FAIL rst_still_hold got act=%b sel=%0d want act=1 sel=2", hold_active, fnd_sel);
      else passes++;
      n = 0;
      do begin cyc(); n++; end while (hold_active === 1'b1 && n < 30);
      total++; if (n < 17 || n > 20) $display("FAIL rst_hold_len got %0d cycles want 17..20", n); else passes++;
   endtask

   task automatic test_round_robin();
      int n, k;
      logic [1:0] seen [3];
      logic [1:0] prev;
      sw = 3'b000; cyc();
      wr_strb = 3'b111; cyc(); wr_strb = 3'b000;
      total++; if (dut.pending_q !== 3'b111) $display("FAIL rr_pend got %b want 111", dut.pending_q); else passes++;
      cyc();
      total++; if (fnd_sel !== 2'd0 || hold_active !== 1'b1)
         $display("FAIL rr_first got sel=%0d act=%b want sel=0 act=1", fnd_sel, hold_active);
      else passes++;
      seen[0] = fnd_sel; seen[1] = 2'd3; seen[2] = 2'd3; prev = fnd_sel; k = 1; n = 0;
      do begin
         cyc(); n++;
         if (hold_active === 1'b1 && fnd_sel !== prev) begin
            if (k < 3) seen[k] = fnd_sel;
            k++;
            prev = fnd_sel;
         end
      end while (hold_active === 1'b1 && n < 80);
      total++; if (k !== 3 || seen[1] !== 2'd1 || seen[2] !== 2'd2)
         $display("FAIL rr_order got %0d grants then %0d,%0d want 3 grants then 1,2", k, seen[1], seen[2]);
      else passes++;
      total++; if (n < 57 || n > 60) $display("FAIL rr_total_len got %0d cycles want 57..60", n); else passes++;
      total++; if (fnd_sel !== 2'd3) $display("FAIL rr_end_sel got %0d want 3", fnd_sel); else passes++;
      wr_strb = 3'b011; cyc(); wr_strb = 3'b000;
      cyc();
      total++; if (fnd_sel !== 2'd0) $display("FAIL rr_wrap_sel got %0d want 0", fnd_sel); else passes++;
      n = 0;
      do begin cyc(); n++; end while (fnd_sel === 2'd0 && n < 30);
      total++; if (fnd_sel !== 2'd1 || hold_active !== 1'b1)
         $display("FAIL rr_wrap_next got sel=%0d act=%b want sel=1 act=1", fnd_sel, hold_active);
      else passes++;
      n = 0;
      do begin cyc(); n++; end while (hold_active === 1'b1 && n < 30);
      total++; if (fnd_sel !== 2'd3 || n < 17 || n > 20)
         $display("FAIL rr_wrap_end got sel=%0d after %0d cycles want sel=3 after 17..20", fnd_sel, n);
      else passes++;
   endtask

   task automatic test_live_update();
      int n, bad;
      slv_reg1 = 8'h10;
      wr_strb = 3'b010; cyc(); wr_strb = 3'b000;
      cyc();
      total++; if (fnd_sel !== 2'd1 || fnd_reg !== 8'h10)
         $display("FAIL live_pre got sel=%0d reg=%h want sel=1 reg=10", fnd_sel, fnd_reg);
      else passes++;
      cycles(2);
      auto_en = 1'b1; sw = 3'b100; slv_reg1 = 8'h20; cyc();
      total++; if (fnd_reg !== 8'h20) $display("FAIL live_reg got %h want 20", fnd_reg); else passes++;
      total++; if (fnd_sel !== 2'd1 || hold_active !== 1'b1)
         $display("FAIL live_state got sel=%0d act=%b want sel=1 act=1", fnd_sel, hold_active);
      else passes++;
      n = 0; bad = 0;
      do begin
         cyc(); n++;
         if (hold_active === 1'b1 && fnd_sel !== 2'd1) bad++;
      end while (hold_active === 1'b1 && n < 30);
      total++; if (bad != 0) $display("FAIL live_ignore_inputs got %0d off-cycles want 0", bad); else passes++;
      total++; if (fnd_sel !== 2'd1 || fnd_reg !== 8'h20)
         $display("FAIL live_to_rot got sel=%0d reg=%h want sel=1 reg=20", fnd_sel, fnd_reg);
      else passes++;
      n = 0;
      do begin cyc(); n++; end while (fnd_sel === 2'd1 && n < 20);
      total++; if (n < 9 || n > 12 || fnd_sel !== 2'd2 || fnd_reg !== 8'hC3)
         $display("FAIL live_rot_dwell got sel=%0d reg=%h after %0d want sel=2 reg=c3 after 9..12",
                  fnd_sel, fnd_reg, n);
      else passes++;
      auto_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_manual();
      test_rotate();
      test_write_hold();
      test_hold_restart();
      test_round_robin();
      test_live_update();
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
